// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU sequencing controller.
// Holds the opcode and FSM encodings plus the instruction field positions.
package alu_ctrl_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 13;
    localparam int RD_HI  = 12;
    localparam int RD_LO  = 10;
    localparam int RS1_HI = 9;
    localparam int RS1_LO = 7;
    localparam int RS2_HI = 6;
    localparam int RS2_LO = 4;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_CMP = 3'b110,
        OP_ILL = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    function automatic logic writes_rd(input opcode_t op);
        return (op != OP_CMP) && (op != OP_ILL);
    endfunction

    function automatic logic keeps_carry(input opcode_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
    endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// Register-file access bus between the controller (master) and the 8x16 register file (slave).
interface alu_ctrl_if;
    import alu_ctrl_pkg::*;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output we, waddr, wdata, raddr1, raddr2, dbg_addr,
        input  rdata1, rdata2, dbg_data
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2, dbg_addr,
        output rdata1, rdata2, dbg_data
    );
endinterface

// File: rtl/regfile_8x16.sv
// Eight 16-bit registers: one synchronous write port, three combinational reads.
// A read of the register being written returns the old value until the edge.
module regfile_8x16
    import alu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    alu_ctrl_if.slave  rf
);

    logic [DATA_W-1:0] mem [8];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                mem[i] <= '0;
            end
        end else if (rf.we) begin
            mem[rf.waddr] <= rf.wdata;
        end
    end

    assign rf.rdata1   = mem[rf.raddr1];
    assign rf.rdata2   = mem[rf.raddr2];
    assign rf.dbg_data = mem[rf.dbg_addr];

endmodule

// File: rtl/alu_ctrl.sv
// Four-phase instruction sequencer around an external ALU and an 8x16 register file.
//   state   | meaning
//   IDLE    | ready for an instruction, captures it on accept
//   READ    | registers op1/op2 from rs1/rs2
//   EXEC    | captures the selected ALU result and carry
//   WB      | done pulse; writes rd and/or flags as the opcode allows
module alu_ctrl
    import alu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [15:0] op1,
    output logic [15:0] op2,
    input  logic [15:0] res_add,
    input  logic [15:0] res_sub,
    input  logic [15:0] res_and,
    input  logic [15:0] res_or,
    input  logic [15:0] res_xor,
    input  logic [15:0] res_not,
    input  logic [15:0] res_cmp,
    input  logic        alu_carry,
    output logic        done,
    output logic        illegal,
    output logic        flag_z,
    output logic        flag_c,
    output logic        flag_n,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    state_t            state, state_nxt;
    logic              accept;
    logic              wb_write;
    logic              wb_flags;
    logic [15:4]       instr_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] res_sel;
    logic              carry_q;
    opcode_t           op;
    logic              unused_bits;

    alu_ctrl_if rf_bus ();

    regfile_8x16 u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf_bus)
    );

    assign unused_bits = ^instr[3:0];
    assign op          = opcode_t'(instr_q[OPC_HI:OPC_LO]);

    assign rf_bus.we       = wb_write;
    assign rf_bus.waddr    = instr_q[RD_HI:RD_LO];
    assign rf_bus.wdata    = result_q;
    assign rf_bus.raddr1   = instr_q[RS1_HI:RS1_LO];
    assign rf_bus.raddr2   = instr_q[RS2_HI:RS2_LO];
    assign rf_bus.dbg_addr = dbg_addr;
    assign dbg_data        = rf_bus.dbg_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        accept      = 1'b0;
        wb_write    = 1'b0;
        wb_flags    = 1'b0;
        case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_READ;
                end
            end
            ST_READ: state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_WB;
            ST_WB: begin
                state_nxt = ST_IDLE;
                wb_write  = writes_rd(op);
                wb_flags  = (op != OP_ILL);
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        res_sel = '0;
        case (op)
            OP_ADD:  res_sel = res_add;
            OP_SUB:  res_sel = res_sub;
            OP_AND:  res_sel = res_and;
            OP_OR:   res_sel = res_or;
            OP_XOR:  res_sel = res_xor;
            OP_NOT:  res_sel = res_not;
            OP_CMP:  res_sel = res_cmp;
            default: res_sel = '0;
        endcase
    end

    // done/illegal are registered on the EXEC->WB edge so they are high exactly during WB
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q  <= '0;
            op1      <= '0;
            op2      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
            flag_n   <= 1'b0;
            done     <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            done    <= (state == ST_EXEC);
            illegal <= (state == ST_EXEC) && (op == OP_ILL);
            if (accept) begin
                instr_q <= instr[15:4];
            end
            if (state == ST_READ) begin
                op1 <= rf_bus.rdata1;
                op2 <= rf_bus.rdata2;
            end
            if (state == ST_EXEC) begin
                result_q <= res_sel;
                carry_q  <= alu_carry;
            end
            if (wb_flags) begin
                flag_z <= (result_q == '0);
                flag_n <= result_q[DATA_W-1];
                flag_c <= keeps_carry(op) ? carry_q : 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed plus randomized bench for alu_ctrl with a behavioural ALU and register/flag model.
`timescale 1ns/100ps
module tb_alu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [15:0] op1, op2;
    logic [15:0] res_add, res_sub, res_and, res_or, res_xor, res_not, res_cmp;
    logic        alu_carry;
    logic        done, illegal;
    logic        flag_z, flag_c, flag_n;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int vectors = 0;
    int miscompares = 0;

    // external ALU stand-in; ovr_en forces every result bus to ovr_val for preloading
    logic [2:0]  cur_op;
    logic        ovr_en;
    logic [15:0] ovr_val;
    logic [16:0] sum17;

    assign sum17   = {1'b0, op1} + {1'b0, op2};
    assign res_add = ovr_en ? ovr_val : sum17[15:0];
    assign res_sub = ovr_en ? ovr_val : op1 - op2;
    assign res_and = ovr_en ? ovr_val : op1 & op2;
    assign res_or  = ovr_en ? ovr_val : op1 | op2;
    assign res_xor = ovr_en ? ovr_val : op1 ^ op2;
    assign res_not = ovr_en ? ovr_val : ~op1;
    assign res_cmp = ovr_en ? ovr_val : op1 - op2;
    assign alu_carry = ovr_en ? 1'b0 :
                       (cur_op == 3'd0) ? sum17[16] :
                       (cur_op == 3'd1 || cur_op == 3'd6) ? (op1 >= op2) : 1'b0;

    logic [15:0] m_reg [8];
    logic        m_z, m_c, m_n;

    alu_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .op1         (op1),
        .op2         (op2),
        .res_add     (res_add),
        .res_sub     (res_sub),
        .res_and     (res_and),
        .res_or      (res_or),
        .res_xor     (res_xor),
        .res_not     (res_not),
        .res_cmp     (res_cmp),
        .alu_carry   (alu_carry),
        .done        (done),
        .illegal     (illegal),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .flag_n      (flag_n),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // flags plus every register through the debug port; finishes on a falling edge
    task automatic check_state(input string tag);
        chk({tag, ":flag_z"}, {15'd0, flag_z}, {15'd0, m_z});
        chk({tag, ":flag_c"}, {15'd0, flag_c}, {15'd0, m_c});
        chk({tag, ":flag_n"}, {15'd0, flag_n}, {15'd0, m_n});
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            chk($sformatf("%s:r%0d", tag, i), dbg_data, m_reg[i]);
        end
        @(negedge clk);
    endtask

    task automatic exec(input string tag, input logic [2:0] opc, input logic [2:0] rd,
                        input logic [2:0] rs1, input logic [2:0] rs2,
                        input logic use_ovr, input logic [15:0] val);
        logic [15:0] a, b, r, old;
        logic        c;
        logic        ill;
        a   = m_reg[rs1];
        b   = m_reg[rs2];
        old = m_reg[rd];
        ill = (opc == 3'd7);
        c   = 1'b0;
        case (opc)
            3'd0: {c, r} = {1'b0, a} + {1'b0, b};
            3'd1, 3'd6: begin r = a - b; c = (a >= b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            default: r = 16'h0000;
        endcase
        if (use_ovr) begin
            r = val;
            c = 1'b0;
        end
        cur_op      = opc;
        ovr_en      = use_ovr;
        ovr_val     = val;
        instr       = {opc, rd, rs1, rs2, 4'($urandom)};
        instr_valid = 1'b1;
        chk({tag, ":ready"}, {15'd0, instr_ready}, 16'd1);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            chk($sformatf("%s:done@%0d", tag, n), {15'd0, done}, {15'd0, (n == 3)});
            chk($sformatf("%s:illegal@%0d", tag, n), {15'd0, illegal}, {15'd0, (n == 3) && ill});
            if (n == 2) begin
                chk({tag, ":op1"}, op1, a);
                chk({tag, ":op2"}, op2, b);
            end
            if (n == 3) begin
                dbg_addr = rd;
                #1;
                chk({tag, ":dbg_old"}, dbg_data, old);
            end
        end
        ovr_en = 1'b0;
        if (opc != 3'd6 && opc != 3'd7) m_reg[rd] = r;
        if (!ill) begin
            m_z = (r == 16'h0000);
            m_n = r[15];
            m_c = c;
        end
        check_state(tag);
    endtask

    task automatic load(input logic [2:0] rd, input logic [15:0] val);
        exec($sformatf("load_r%0d", rd), 3'd3, rd, 3'd0, 3'd0, 1'b1, val);
    endtask

    initial begin
        int dcnt;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        dbg_addr    = 3'd0;
        cur_op      = 3'd0;
        ovr_en      = 1'b0;
        ovr_val     = 16'h0000;
        for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
        m_z = 1'b0; m_c = 1'b0; m_n = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst:op1", op1, 16'h0000);
        chk("rst:op2", op2, 16'h0000);
        chk("rst:done", {15'd0, done}, 16'd0);
        chk("rst:illegal", {15'd0, illegal}, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst:ready_after", {15'd0, instr_ready}, 16'd1);
        check_state("rst");

        // ADD overflow to zero
        load(3'd1, 16'hFFFF);
        load(3'd2, 16'h0001);
        exec("add_wrap", 3'd0, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0);
        chk("add_wrap:r3", m_reg[3], 16'h0000);

        // SUB equal operands, then CMP leaves rd untouched
        load(3'd1, 16'h0005);
        load(3'd2, 16'h0005);
        load(3'd5, 16'h1234);
        exec("sub_eq", 3'd1, 3'd4, 3'd1, 3'd2, 1'b0, 16'h0);
        exec("cmp_eq", 3'd6, 3'd5, 3'd1, 3'd2, 1'b0, 16'h0);

        // NOT then XOR of a register with itself
        load(3'd1, 16'h8000);
        exec("not", 3'd5, 3'd6, 3'd1, 3'd0, 1'b0, 16'h0);
        exec("xor_self", 3'd4, 3'd7, 3'd6, 3'd6, 1'b0, 16'h0);

        // illegal opcode with N flag set beforehand
        load(3'd4, 16'h8001);
        load(3'd2, 16'hBEEF);
        exec("illegal", 3'd7, 3'd2, 3'd1, 3'd3, 1'b0, 16'h0);

        // valid held high for 12 cycles: three back-to-back ADD r1,r1,r1
        load(3'd1, 16'h0001);
        cur_op      = 3'd0;
        instr       = {3'd0, 3'd1, 3'd1, 3'd1, 4'h0};
        instr_valid = 1'b1;
        dcnt        = 0;
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("hold:ready@%0d", k), {15'd0, instr_ready}, {15'd0, (k % 4 == 0)});
            if (done) dcnt++;
            @(posedge clk);
            #1;
        end
        instr_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("hold:done_count", 16'(dcnt), 16'd3);
        m_reg[1] = 16'h0008;
        m_z = 1'b0; m_c = 1'b0; m_n = 1'b0;
        check_state("hold");

        // randomized instructions, some preceded by random preloads
        for (int t = 0; t < 24; t++) begin
            if (t % 3 == 0) load(3'($urandom_range(0, 7)), 16'($urandom));
            exec($sformatf("rnd%0d", t), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0, 16'h0);
        end

        // reset during EXEC abandons the instruction
        load(3'd1, 16'h1111);
        load(3'd2, 16'h2222);
        cur_op      = 3'd0;
        instr       = {3'd0, 3'd3, 3'd1, 3'd2, 4'h0};
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("midrst:done_low", {15'd0, done}, 16'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst:ready", {15'd0, instr_ready}, 16'd1);
        chk("midrst:done", {15'd0, done}, 16'd0);
        for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
        m_z = 1'b0; m_c = 1'b0; m_n = 1'b0;
        check_state("midrst");
        repeat (3) begin
            @(negedge clk);
            chk("midrst:no_done", {15'd0, done}, 16'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 The block SHALL have these parameters: none; widths are fixed at 16-bit data, 3-bit register address and 3-bit opcode.
REQ-002 The block SHALL have these ports, in this order:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- instr_valid  in  1  instruction offered.
- instr  in  16  [15:13] opcode, [12:10] rd, [9:7] rs1, [6:4] rs2, [3:0] ignored.
- instr_ready  out  1  block can accept an instruction.
- op1  out  16  first operand driven to ALU.
- op2  out  16  second operand driven to ALU.
- res_add, res_sub, res_and, res_or, res_xor, res_not, res_cmp  in  16 each  ALU result buses.
- alu_carry  in  1  ALU carry-out.
- done  out  1  one-cycle pulse when an instruction retires.
- illegal  out  1  one-cycle pulse, with done, for opcode 111.
- flag_z, flag_c, flag_n  out  1 each  registered zero, carry and negative flags.
- dbg_addr  in  3  debug register-file read address.
- dbg_data  out  16  combinational read of register dbg_addr.

Function
REQ-003 Opcodes SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT (uses rs1 only), 110 CMP, 111 illegal.
REQ-004 The FSM SHALL have states IDLE, READ, EXEC and WB, with transitions IDLE->READ on instr_valid&instr_ready, READ->EXEC, EXEC->WB and WB->IDLE unconditionally.
REQ-005 instr_ready SHALL be 1 only in IDLE; instr SHALL be captured into an internal register on acceptance.
REQ-006 In READ, op1 and op2 SHALL be registered from regfile[rs1] and regfile[rs2]; op1 and op2 SHALL hold their values until the next READ.
REQ-007 In EXEC, the block SHALL capture the result bus selected by the opcode, together with alu_carry.
REQ-008 In WB, for opcodes ADD, SUB, AND, OR, XOR and NOT, the captured result SHALL be written to regfile[rd].
REQ-009 In WB, CMP SHALL NOT write the register file; only the flags SHALL update.
REQ-010 In WB, opcode 111 SHALL write neither registers nor flags, and SHALL pulse illegal.
REQ-011 The flags SHALL update in WB as follows:
- Z = (result == 0).
- N = result[15].
- C = captured carry for ADD, SUB and CMP; C = 0 for AND, OR, XOR and NOT.
REQ-012 done SHALL pulse for exactly the WB cycle; the accept-to-done latency SHALL be fixed at 3 cycles after the accept edge.
REQ-013 The next instruction SHALL be acceptable in the cycle after WB, giving a throughput of one instruction per 4 cycles.
REQ-014 instr_valid held high SHALL be accepted again only in IDLE; there SHALL be no drop and no double-issue.
REQ-015 A register write to rd and a dbg_addr read of the same register in the WB cycle SHALL return the old value on dbg_data; the new value SHALL appear from the next cycle.
REQ-016 rd equal to rs1 or rs2 SHALL be legal; operands SHALL be read before the writeback.

Reset
REQ-017 While rst_n=0 at a clk edge, the block SHALL set:
- state = IDLE;
- op1 = op2 = 0;
- the captured instruction and result to 0;
- flag_z = flag_c = flag_n = 0;
- done = illegal = 0;
- all 8 registers to 0.
REQ-018 Reset asserted mid-instruction (READ, EXEC or WB) SHALL abandon the instruction with no writeback and no done pulse.
REQ-019 instr_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-020 A shared package alu_ctrl_pkg SHALL hold the opcode enum, the FSM state enum and the instr field bit-position constants.
REQ-021 The register file SHALL be a sub-module regfile_8x16 with:
- one synchronous write port;
- two combinational read ports for rs1 and rs2;
- one combinational debug read port.
REQ-022 The ALU itself SHALL remain external; the block SHALL only drive operands and consume results.

Verification
REQ-023 Preload r1=FFFF and r2=0001, then issue ADD r3,r1,r2: the bench SHALL see r3=0000, Z=1, C=1, N=0, and done exactly 3 cycles after accept.
REQ-024 With r1=0005 and r2=0005, issue SUB r4,r1,r2 followed by CMP r1,r2 with rd=r5: r4=0000 and Z=1, C=1; r5 SHALL be unchanged after CMP.
REQ-025 With r1=8000, issue NOT r6,r1: r6=7FFF, N=0, C=0. Then issue XOR r7,r6,r6: r7=0000 and Z=1.
REQ-026 Hold instr_valid high for 12 cycles with ADD r1,r1,r1 and r1=0001: exactly 3 done pulses, r1=0008, and instr_ready high only in IDLE.
REQ-027 Issue opcode 111 with rd=r2: illegal and done pulse together, and r2 and all flags are unchanged.
REQ-028 Assert rst_n=0 during EXEC of ADD r3: no done pulse, r3=0000, all flags 0, and instr_ready=1 in the cycle after release.
